// File: rtl/clip_pkg.sv
// Shared types and constants for the two-clip recorder sequencer and the
// seven-segment display interface.
package clip_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } state_t;

  localparam logic CLIP1 = 1'b0;
  localparam logic CLIP2 = 1'b1;
endpackage

// File: rtl/button_debouncer.sv
// Raw button -> 2-flop synchronizer -> stable-count debouncer -> one-cycle
// pulse on each accepted press.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic i_btn,
  output logic o_pulse
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_level_d;
  logic             r_pulse;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_sync    <= '0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_pulse   <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_btn};
      r_level_d <= r_level;
      r_pulse   <= r_level & ~r_level_d;
      // Any sample matching the accepted level restarts the stability count.
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_pulse = r_pulse;
endmodule

// File: rtl/clip_controller.sv
// Record/playback sequencer for the two-clip recorder. Define CLIP_LOOP_EN to
// loop playback at end of clip instead of returning to IDLE.
module clip_controller
  import clip_pkg::*;
#(
  parameter int ADDR_W          = 16,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            btn_record,
  input  logic            btn_play,
  input  logic            clip_sel,
  input  logic            sample_tick,
  output logic            record,
  output logic            play,
  output logic            recordNum,
  output logic            clipPlayNum,
  output logic [ADDR_W:0] mem_addr,
  output logic            mem_we,
  output logic            mem_re
);
`ifdef CLIP_LOOP_EN
  localparam logic LOOP = 1'b1;
`else
  localparam logic LOOP = 1'b0;
`endif
  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

  logic                 w_rec_p, w_play_p;
  state_t               r_state, w_next;
  logic                 r_cur;
  logic [ADDR_W-1:0]    r_offset;
  logic [1:0][ADDR_W:0] r_len;
  logic [ADDR_W:0]      w_cur_len, w_last_off;
  logic                 w_last, w_wr, w_rd;
  logic                 r_record, r_play, r_rec_num, r_play_num;
  logic [ADDR_W:0]      r_addr;
  logic                 r_we, r_re, r_end;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rec (
    .clock(clock), .reset(reset), .i_btn(btn_record), .o_pulse(w_rec_p));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_play (
    .clock(clock), .reset(reset), .i_btn(btn_play), .o_pulse(w_play_p));

  assign w_cur_len  = r_len[r_cur];
  assign w_last_off = w_cur_len - 1'b1;
  assign w_last     = ({1'b0, r_offset} == w_last_off);

  // Terminal conditions are evaluated one cycle after the final strobe, so
  // the strobe cycle itself is still inside RECORD/PLAY.
  always_comb begin
    w_next = r_state;
    w_wr   = 1'b0;
    w_rd   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_rec_p)                              w_next = RECORD;
        else if (w_play_p && r_len[clip_sel] != '0) w_next = PLAY;
      end
      RECORD: begin
        if (w_rec_p || w_cur_len == FULL) w_next = IDLE;
        else if (sample_tick)             w_wr   = 1'b1;
      end
      PLAY: begin
        if (w_play_p)              w_next = IDLE;
        else if (!LOOP && r_end)   w_next = IDLE;
        else if (sample_tick)      w_rd   = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_cur      <= CLIP1;
      r_offset   <= '0;
      r_len      <= '0;
      r_record   <= 1'b0;
      r_play     <= 1'b0;
      r_rec_num  <= CLIP1;
      r_play_num <= CLIP1;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_re       <= 1'b0;
      r_end      <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_record <= (w_next == RECORD);
      r_play   <= (w_next == PLAY);
      r_we     <= w_wr;
      r_re     <= w_rd;
      r_end    <= w_rd && w_last;
      if (r_state == IDLE && w_next == RECORD) begin
        r_cur           <= clip_sel;
        r_offset        <= '0;
        r_len[clip_sel] <= '0;
        r_rec_num       <= clip_sel;
      end
      if (r_state == IDLE && w_next == PLAY) begin
        r_cur      <= clip_sel;
        r_offset   <= '0;
        r_play_num <= clip_sel;
      end
      if (w_wr || w_rd) r_addr <= {r_cur, r_offset};
      if (w_wr) begin
        r_offset     <= r_offset + 1'b1;
        r_len[r_cur] <= w_cur_len + 1'b1;
      end
      if (w_rd) r_offset <= w_last ? '0 : r_offset + 1'b1;
    end
  end

  assign record      = r_record;
  assign play        = r_play;
  assign recordNum   = r_rec_num;
  assign clipPlayNum = r_play_num;
  assign mem_addr    = r_addr;
  assign mem_we      = r_we;
  assign mem_re      = r_re;
endmodule
